// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//   Measures the frequency of an asynchronous toggle from a PLL output by
//   counting its rising edges over a fixed gate window of CLK cycles. The
//   count is checked against an expected range. LOCKED asserts after
//   LOCK_WINDOWS consecutive in-range windows. LOSS is a sticky flag that
//   records lock being lost to an out-of-range window.
//
// Ports
//   CLK          reference clock
//   RST          synchronous, active-high reset
//   EN           monitor enable; low parks the monitor in IDLE
//   TICK_IN      asynchronous toggle, frequency < CLK/2
//   CLR_LOSS     one-cycle pulse that clears LOSS
//   COUNT        rising-edge count of the last completed window (saturating)
//   COUNT_VALID  one-cycle pulse when COUNT/IN_RANGE update
//   IN_RANGE     last window satisfied EXP_MIN <= COUNT <= EXP_MAX
//   LOCKED       LOCK_WINDOWS consecutive in-range windows seen
//   LOSS         sticky; set when LOCKED drops on an out-of-range window
//
// State     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | disabled; counters held cleared
// S_ACQUIRE | counting consecutive in-range windows toward lock
// S_LOCKED  | lock established; one out-of-range window drops it

module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 1000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 0,
  parameter int EXP_MAX      = 65535,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             TICK_IN,
  input  logic             CLR_LOSS,
  output logic [CNT_W-1:0] COUNT,
  output logic             COUNT_VALID,
  output logic             IN_RANGE,
  output logic             LOCKED,
  output logic             LOSS
);

  localparam int WIN_W  = $clog2(GATE_CYCLES);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              tick_s1, tick_s2, tick_s3;
  logic              tick_rise;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_final;
  logic [GOOD_W-1:0] good_cnt, good_d, good_next;
  logic              window_done;
  logic              range_ok;
  logic              loss_event;
  longint            count_l;

  // tick_s1/tick_s2 form the synchronizer; tick_s3 is only for edge detect
  assign tick_rise   = tick_s2 & ~tick_s3;
  assign window_done = EN && (win_cnt == WIN_LAST);

  // An edge seen in the terminal cycle still belongs to this window
  assign edge_final = (tick_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  // Signed 64-bit compare keeps the range check meaningful for any bounds
  assign count_l   = longint'(edge_final);
  assign range_ok  = (count_l >= longint'(EXP_MIN)) && (count_l <= longint'(EXP_MAX));
  assign good_next = good_cnt + 1'b1;

  assign LOCKED = (state_q == S_LOCKED);

  always_comb begin
    state_d    = state_q;
    good_d     = good_cnt;
    loss_event = 1'b0;
    if (!EN) begin
      state_d = S_IDLE;
      good_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
        S_ACQUIRE: begin
          if (window_done) begin
            if (!range_ok) begin
              good_d = '0;
            end else if (good_next == GOOD_LOCK) begin
              state_d = S_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_next;
            end
          end
        end
        S_LOCKED: begin
          if (window_done && !range_ok) begin
            state_d    = S_ACQUIRE;
            good_d     = '0;
            loss_event = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      good_cnt    <= '0;
      tick_s1     <= 1'b0;
      tick_s2     <= 1'b0;
      tick_s3     <= 1'b0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      COUNT       <= '0;
      COUNT_VALID <= 1'b0;
      IN_RANGE    <= 1'b0;
      LOSS        <= 1'b0;
    end else begin
      tick_s1     <= TICK_IN;
      tick_s2     <= tick_s1;
      tick_s3     <= tick_s2;
      state_q     <= state_d;
      good_cnt    <= good_d;
      COUNT_VALID <= window_done;

      if (!EN) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (window_done) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        COUNT    <= edge_final;
        IN_RANGE <= range_ok;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_final;
      end

      // A loss in the same cycle as a clear request must not be lost
      if (loss_event) begin
        LOSS <= 1'b1;
      end else if (CLR_LOSS) begin
        LOSS <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
module tb_clk_freq_monitor;

  localparam int G     = 100;
  localparam int W     = 16;
  localparam int EMIN  = 24;
  localparam int EMAX  = 26;
  localparam int LW    = 4;
  localparam int W2    = 4;
  localparam int E2MIN = 14;
  localparam int E2MAX = 15;
  localparam int MAXC  = (1 << W) - 1;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, tick = 1'b0, clr = 1'b0;

  logic [W-1:0]  count;
  logic          count_valid, in_range, locked, loss;
  logic [W2-1:0] count2;
  logic          count_valid2, in_range2, locked2, loss2;

  clk_freq_monitor #(.GATE_CYCLES(G), .CNT_W(W), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                     .LOCK_WINDOWS(LW)) dut (
    .CLK(clk), .RST(rst), .EN(en), .TICK_IN(tick), .CLR_LOSS(clr),
    .COUNT(count), .COUNT_VALID(count_valid), .IN_RANGE(in_range),
    .LOCKED(locked), .LOSS(loss));

  clk_freq_monitor #(.GATE_CYCLES(G), .CNT_W(W2), .EXP_MIN(E2MIN), .EXP_MAX(E2MAX),
                     .LOCK_WINDOWS(LW)) dut_sat (
    .CLK(clk), .RST(rst), .EN(en), .TICK_IN(tick), .CLR_LOSS(clr),
    .COUNT(count2), .COUNT_VALID(count_valid2), .IN_RANGE(in_range2),
    .LOCKED(locked2), .LOSS(loss2));

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  // Reference model: window bookkeeping from the behavioural rules.
  // A rise applied before clock edge i is counted at edge i+2.
  int m_win, m_cnt, m_count, m_good;
  bit m_valid, m_inr, m_locked, m_loss;
  bit m_prev, m_pipe0, m_pipe1;

  function automatic bit tick80(input int p);
    return ((p / 2) % 2) == 1;
  endfunction

  function automatic logic [W+3:0] exp_vec();
    return {W'(m_count), m_valid, m_inr, m_locked, m_loss};
  endfunction

  task automatic model_update(input bit r, input bit e, input bit t, input bit c);
    int contrib, tot;
    bit ev;
    if (r) begin
      m_win = 0; m_cnt = 0; m_count = 0; m_good = 0;
      m_valid = 0; m_inr = 0; m_locked = 0; m_loss = 0;
      m_prev = 0; m_pipe0 = 0; m_pipe1 = 0;
      return;
    end
    contrib = int'(m_pipe1);
    m_pipe1 = m_pipe0;
    m_pipe0 = t & ~m_prev;
    m_prev  = t;
    m_valid = 0;
    ev      = 0;
    if (!e) begin
      m_win = 0; m_cnt = 0; m_good = 0; m_locked = 0;
    end else begin
      tot = m_cnt + contrib;
      if (tot > MAXC) tot = MAXC;
      if (m_win == G - 1) begin
        m_count = tot;
        m_inr   = (tot >= EMIN) && (tot <= EMAX);
        m_valid = 1;
        m_win   = 0;
        m_cnt   = 0;
        if (m_inr) begin
          if (!m_locked) begin
            m_good++;
            if (m_good >= LW) begin
              m_locked = 1;
              m_good   = 0;
            end
          end
        end else begin
          if (m_locked) ev = 1;
          m_locked = 0;
          m_good   = 0;
        end
      end else begin
        m_win++;
        m_cnt = tot;
      end
    end
    if (ev) m_loss = 1;
    else if (c) m_loss = 0;
  endtask

  task automatic step(input bit r, input bit e, input bit t, input bit c);
    @(negedge clk);
    rst = r; en = e; tick = t; clr = c;
    @(posedge clk);
    model_update(r, e, t, c);
    #1;
  endtask

  task automatic test_reset();
    logic [W+3:0] obs;
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0, i[0], 1'b0);
      obs = {count, count_valid, in_range, locked, loss};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, obs);
      end
    end
  endtask

  task automatic test_acquire();
    logic [W+3:0] obs;
    int n_valid = 0, last = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      obs = {count, count_valid, in_range, locked, loss};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL acquire_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (count_valid) begin
        n_valid++;
        checks++;
        if (count < 24 || count > 26 || in_range !== 1'b1) begin
          errors++;
          $display("FAIL acquire_count n=%0d got=%0d in_range=%b exp=24..26 in_range=1",
                   n_valid, count, in_range);
        end
        checks++;
        if (locked !== (n_valid >= LW)) begin
          errors++;
          $display("FAIL acquire_lock n=%0d got=%b exp=%b", n_valid, locked, n_valid >= LW);
        end
        if (n_valid > 1) begin
          checks++;
          if (cyc - last != G) begin
            errors++;
            $display("FAIL acquire_period got=%0d exp=%0d", cyc - last, G);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (n_valid != 4 || locked !== 1'b1) begin
      errors++;
      $display("FAIL acquire_windows got=%0d locked=%b exp=4 locked=1", n_valid, locked);
    end
  endtask

  task automatic test_loss_relock();
    logic [W+3:0] obs;
    bit hold;
    int guard = 0;
    while (!count_valid && guard < 200) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      guard++;
    end
    checks++;
    if (!count_valid) begin
      errors++;
      $display("FAIL loss_wait_valid got=timeout exp=count_valid");
    end
    hold = tick;
    for (int i = 0; i < G; i++) begin
      step(1'b0, 1'b1, hold, 1'b0);
      obs = {count, count_valid, in_range, locked, loss};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL loss_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if (count_valid !== 1'b1 || count > 1 || in_range !== 1'b0 || locked !== 1'b0 || loss !== 1'b1) begin
      errors++;
      $display("FAIL loss_event got valid=%b count=%0d in_range=%b locked=%b loss=%b exp 1,<=1,0,0,1",
               count_valid, count, in_range, locked, loss);
    end
    for (int i = 0; i < 4 * G + 10; i++) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      obs = {count, count_valid, in_range, locked, loss};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL relock_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || loss !== 1'b1) begin
      errors++;
      $display("FAIL relock_state got locked=%b loss=%b exp locked=1 loss=1", locked, loss);
    end
    step(1'b0, 1'b1, tick80(phase), 1'b1);
    phase++;
    checks++;
    if (loss !== 1'b0) begin
      errors++;
      $display("FAIL clr_loss got=%b exp=0", loss);
    end
  endtask

  task automatic test_too_fast();
    int n_valid = 0;
    bit t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = ~t;
      step(1'b0, 1'b0, t, 1'b0);
    end
    for (int i = 0; i < 8 * G; i++) begin
      t = ~t;
      step(1'b0, 1'b1, t, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL fast_locked t=%0t got=%b exp=0", $time, locked);
      end
      if (count_valid) begin
        n_valid++;
        checks++;
        if (count !== W'(50) || in_range !== 1'b0) begin
          errors++;
          $display("FAIL fast_count got=%0d in_range=%b exp=50 in_range=0", count, in_range);
        end
      end
    end
    checks++;
    if (n_valid != 8) begin
      errors++;
      $display("FAIL fast_windows got=%0d exp=8", n_valid);
    end
  endtask

  task automatic test_en_drop();
    logic [W+3:0] obs;
    logic [W-1:0] cnt_hold;
    logic         loss_hold;
    int guard = 0, gap = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, tick80(phase), 1'b0);
      phase++;
    end
    while (!(locked && count_valid) && guard < 600) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      guard++;
    end
    checks++;
    if (!(locked && count_valid)) begin
      errors++;
      $display("FAIL endrop_lock got=timeout exp=locked");
    end
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
    end
    cnt_hold  = count;
    loss_hold = loss;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, tick80(phase), 1'b0);
      phase++;
      obs = {count, count_valid, in_range, locked, loss};
      checks++;
      if (count_valid !== 1'b0 || locked !== 1'b0 || count !== cnt_hold || loss !== loss_hold
          || obs !== exp_vec()) begin
        errors++;
        $display("FAIL endrop_gap i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    do begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      gap++;
    end while (!count_valid && gap < 200);
    checks++;
    if (gap != G) begin
      errors++;
      $display("FAIL endrop_restart got=%0d exp=%0d", gap, G);
    end
  endtask

  task automatic test_random();
    logic [W+3:0] obs;
    int mode;
    bit t, hold, e, c;
    t = tick;
    for (int w = 0; w < 24; w++) begin
      mode = $urandom_range(0, 3);
      hold = $urandom_range(0, 1);
      for (int i = 0; i < G; i++) begin
        case (mode)
          0:       t = tick80(phase);
          1:       t = $urandom_range(0, 1);
          2:       t = hold;
          default: t = ~t;
        endcase
        phase++;
        e = ($urandom_range(0, 299) != 0);
        c = ($urandom_range(0, 49) == 0);
        step(1'b0, e, t, c);
        obs = {count, count_valid, in_range, locked, loss};
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL random_model w=%0d i=%0d got=%h exp=%h", w, i, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_saturation();
    int n_valid = 0, guard = 0;
    bit hold;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, tick80(phase), 1'b0);
      phase++;
    end
    while (n_valid < 5 && guard < 700) begin
      step(1'b0, 1'b1, tick80(phase), 1'b0);
      phase++;
      guard++;
      if (count_valid2) begin
        n_valid++;
        checks++;
        if (count2 !== W2'(15) || in_range2 !== 1'b1 || locked2 !== (n_valid >= LW)) begin
          errors++;
          $display("FAIL sat_count n=%0d got=%0d in_range=%b locked=%b exp=15 1 %b",
                   n_valid, count2, in_range2, locked2, n_valid >= LW);
        end
      end
    end
    checks++;
    if (n_valid != 5 || locked2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_lock got=%0d locked=%b exp=5 locked=1", n_valid, locked2);
    end
    hold = tick;
    step(1'b0, 1'b1, hold, 1'b1);
    checks++;
    if (loss2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr got=%b exp=0", loss2);
    end
    guard = 0;
    while (m_win != G - 1 && guard < 200) begin
      step(1'b0, 1'b1, hold, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1, hold, 1'b1);
    checks++;
    if (count_valid2 !== 1'b1 || in_range2 !== 1'b0 || locked2 !== 1'b0 || loss2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_coincide got valid=%b in_range=%b locked=%b loss=%b exp 1,0,0,1",
               count_valid2, in_range2, locked2, loss2);
    end
    step(1'b0, 1'b1, hold, 1'b0);
    checks++;
    if (loss2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_loss_hold got=%b exp=1", loss2);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_loss_relock();
    test_too_fast();
    test_en_drop();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
